timer_scheduler: RTL
====================

# timer_scheduler

Multi-channel millisecond timer and interrupt scheduler for the processor. It consumes the 1 kHz strobe produced by the system frequency divider and runs N_CH independent countdown channels, each programmable by the processor as one-shot or periodic. Expired channels are arbitrated round-robin onto a single interrupt line with a request/acknowledge handshake.

## Interface
- N_CH, 4: number of timer channels (2..8)
- CNT_W, 16: width of period/count registers, in ticks (ms)
- CH_W, 2: width of channel index, = ceil(log2(N_CH))

- clock  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  1 kHz strobe, one clock cycle high per period
- wr_en  in  1  write strobe for channel configuration
- wr_ch  in  CH_W  channel addressed by write
- wr_period  in  CNT_W  period in ticks; 0 = stop channel
- wr_periodic  in  1  1 = auto-reload, 0 = one-shot
- irq  out  1  interrupt request, level, held until acknowledged
- irq_ch  out  CH_W  channel being signalled, valid while irq=1
- irq_ack  in  1  one-cycle acknowledge from processor
- busy  out  N_CH  channel running
- pend  out  N_CH  channel expired, not yet acknowledged
- ovr  out  N_CH  channel expired again while pend was set

## Operation
- Per channel: count[CNT_W], reload[CNT_W], periodic bit, state IDLE/RUN (busy = RUN).
- Write, wr_period≠0: count←wr_period, reload←wr_period, periodic←wr_periodic, state←RUN. Restarts a running channel; pend/ovr untouched.
- Write, wr_period=0: state←IDLE; count, reload → 0.
- wr_ch ≥ N_CH: write ignored.
- On tick, each RUN channel: if count==1 → expire; else count←count−1.
- Expire: pend←1 (if pend already 1, ovr←1); periodic → count←reload, stay RUN; one-shot → state IDLE.
- Write and tick in same cycle on same channel: write wins; that tick neither decrements nor expires the channel.
- Arbiter FSM, states ARB_IDLE, ARB_REQ:
  - ARB_IDLE: if pend≠0, pick first set bit searching from (last+1) mod N_CH upward with wrap; irq_ch←winner, irq←1, → ARB_REQ.
  - ARB_REQ: hold irq, irq_ch stable. On irq_ack: pend[irq_ch]←0, ovr[irq_ch]←0, last←irq_ch, irq←0, → ARB_IDLE.
  - irq_ack in ARB_IDLE: ignored.
  - Ack coinciding with a new expiry of the same channel: pend stays 1, ovr←0 (new event, not an overrun).
- Stopping a channel does not clear its pend; an outstanding request is still delivered.

## Timing
- Reset: irq=0, irq_ch=0, busy=0, pend=0, ovr=0; all counts/reloads 0, all channels IDLE, FSM ARB_IDLE, last=N_CH−1 (channel 0 wins first).
- Reset asserted mid-operation: all state returns to the above immediately; outstanding requests lost.
- Write at edge t: busy visible after t.
- Period P: expiry on the P-th tick strictly after the write edge; pend rises at the edge sampling that tick.
- irq rises one clock after pend becomes visible (≥1 idle cycle in ARB_IDLE between requests).
- irq falls at the edge sampling irq_ack; next request earliest one clock later.
- Periodic channel: consecutive expiries exactly P ticks apart; no drift across reload.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset, write ch0 P=3 one-shot, three ticks → pend[0] after 3rd tick, irq=1, irq_ch=0 next cycle; ack → irq=0, pend=0, busy[0]=0.
- ch1 P=2 periodic, six ticks, ack each → three requests on ch1, ticks 2/4/6; busy[1] stays 1.
- ch0..3 all P=1, one tick → pend=4'b1111; with immediate acks irq_ch sequence 0,1,2,3; then ch2 alone and ch0 expire with last=3 → order 0,2.
- ch3 P=1 periodic, two ticks without ack → ovr[3]=1 after 2nd tick, single request; ack clears pend[3], ovr[3].
- Write ch2 P=5 in same cycle as tick, then 5 more ticks → expiry on 5th following tick only; write P=0 mid-count → busy[2]=0, no expiry.
- reset_n pulsed low while irq=1 and channels running → all outputs 0 asynchronously, no request after release.

Source files
------------

// File: rtl/timer_scheduler.sv
// timer_scheduler: N_CH independent millisecond countdown channels (one-shot or
// periodic) driven by a 1 kHz tick strobe. Expired channels are delivered
// round-robin on a single level interrupt with a request/acknowledge handshake.
module timer_scheduler #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_period,
    input  logic              wr_periodic,
    output logic              irq,
    output logic [CH_W-1:0]   irq_ch,
    input  logic              irq_ack,
    output logic [N_CH-1:0]   busy,
    output logic [N_CH-1:0]   pend,
    output logic [N_CH-1:0]   ovr
);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_REQ  = 1'b1
    } arb_t;

    // Channel state
    logic [CNT_W-1:0] r_count  [N_CH];
    logic [CNT_W-1:0] r_reload [N_CH];
    logic [N_CH-1:0]  r_periodic;
    logic [N_CH-1:0]  r_busy;
    logic [N_CH-1:0]  r_pend;
    logic [N_CH-1:0]  r_ovr;

    // Arbiter state
    arb_t             r_state;
    arb_t             w_state_nxt;
    logic [CH_W-1:0]  r_irq_ch;
    logic [CH_W-1:0]  r_last;

    // Per-channel decode and round-robin selection
    logic [N_CH-1:0]  w_wr_hit;
    logic [N_CH-1:0]  w_expire;
    logic [N_CH-1:0]  w_ack_hit;
    logic [CH_W-1:0]  w_winner;
    int               w_dist;
    int               w_best;

    // Decode writes, expiries and acknowledges per channel. A write to a
    // channel masks that channel's tick in the same cycle. Addresses at or
    // above N_CH match no channel, so such writes fall away naturally.
    always_comb begin
        w_wr_hit  = '0;
        w_expire  = '0;
        w_ack_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_wr_hit[i]  = wr_en && (wr_ch == CH_W'(i));
            w_expire[i]  = tick && r_busy[i] && (r_count[i] == CNT_W'(1)) && !w_wr_hit[i];
            w_ack_hit[i] = irq_ack && (r_state == ARB_REQ) && (r_irq_ch == CH_W'(i));
        end
    end

    // Round-robin pick: the pending channel at the smallest rotational
    // distance after the last serviced channel wins.
    always_comb begin
        w_winner = '0;
        w_best   = N_CH;
        w_dist   = 0;
        for (int i = 0; i < N_CH; i++) begin
            w_dist = (i + 2 * N_CH - int'(r_last) - 1) % N_CH;
            if (r_pend[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_winner = CH_W'(i);
            end
        end
    end

    // Channel counters, configuration and pending/overrun flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_count[i]  <= '0;
                r_reload[i] <= '0;
            end
            r_periodic <= '0;
            r_busy     <= '0;
            r_pend     <= '0;
            r_ovr      <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_wr_hit[i]) begin
                    if (wr_period != '0) begin
                        r_count[i]    <= wr_period;
                        r_reload[i]   <= wr_period;
                        r_periodic[i] <= wr_periodic;
                        r_busy[i]     <= 1'b1;
                    end else begin
                        r_count[i]  <= '0;
                        r_reload[i] <= '0;
                        r_busy[i]   <= 1'b0;
                    end
                end else if (tick && r_busy[i]) begin
                    if (r_count[i] == CNT_W'(1)) begin
                        // Reload from the stored period so periodic expiries
                        // stay exactly one period apart.
                        if (r_periodic[i]) begin
                            r_count[i] <= r_reload[i];
                        end else begin
                            r_busy[i] <= 1'b0;
                        end
                    end else begin
                        r_count[i] <= r_count[i] - CNT_W'(1);
                    end
                end

                // An ack landing with a fresh expiry keeps the channel pending
                // as a new event rather than flagging an overrun.
                if (w_ack_hit[i]) begin
                    r_pend[i] <= w_expire[i];
                    r_ovr[i]  <= 1'b0;
                end else if (w_expire[i]) begin
                    r_pend[i] <= 1'b1;
                    if (r_pend[i]) begin
                        r_ovr[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Arbiter state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbiter next state: grant from registered pend, release on ack
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (|r_pend) w_state_nxt = ARB_REQ;
            ARB_REQ:  if (irq_ack) w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    // Granted channel and round-robin pointer; last starts at N_CH-1 so
    // channel 0 has first priority after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_ch <= '0;
            r_last   <= CH_W'(N_CH - 1);
        end else if ((r_state == ARB_IDLE) && (|r_pend)) begin
            r_irq_ch <= w_winner;
        end else if ((r_state == ARB_REQ) && irq_ack) begin
            r_last <= r_irq_ch;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        irq    = (r_state == ARB_REQ);
        irq_ch = r_irq_ch;
        busy   = r_busy;
        pend   = r_pend;
        ovr    = r_ovr;
    end

endmodule
